serial_byte_collector: RTL and testbench

Downstream neighbour of the byte-serializing FIFO: consumes its LSB-first serial bit stream (`fifo_out` / `fifo_out_valid`), reassembles `DATA_W`-bit words and presents them on a valid/ready parallel port through a small output buffer. It also drives the FIFO's `rd_en` request, asserting it only when it can absorb a whole word, and flags fragmented words and buffer overflow.

---
 rtl/serial_byte_collector_pkg.sv | 6 +
 rtl/serial_byte_collector_out_buf.sv | 51 +++++
 rtl/serial_byte_collector.sv | 58 +++++
 tb/tb_serial_byte_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_byte_collector_pkg.sv
// serial_byte_collector_pkg: word geometry shared with the upstream serializing FIFO
package serial_byte_collector_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = $clog2(DEF_DATA_W);
  localparam int DEF_BUF_D  = 2;
endpackage

// File: rtl/serial_byte_collector_out_buf.sv
// collector_out_buf: circular valid/ready word buffer with sticky overflow on a dropped push
module collector_out_buf
  import serial_byte_collector_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BUF_D  = DEF_BUF_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ovf
);
  localparam int PW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int CW = $clog2(BUF_D + 1);
  logic [DATA_W-1:0] r_mem [BUF_D];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic              w_pop, w_full, w_wr;
  always_comb begin
    w_pop  = o_valid & i_ready;
    w_full = r_cnt == CW'(BUF_D);
    w_wr   = i_push & (~w_full | w_pop);
  end
  assign o_valid = r_cnt != '0;
  assign o_data  = r_mem[r_rp];
  assign o_ovf   = r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= (r_wp == PW'(BUF_D - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= (r_rp == PW'(BUF_D - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
      // a set in the same cycle as a clear wins
      r_ovf <= (i_push & w_full & ~w_pop) | (r_ovf & ~i_clr);
    end
  end
endmodule

// File: rtl/serial_byte_collector.sv
// serial_byte_collector: reassembles LSB-first serial bits into words behind a valid/ready buffer
module serial_byte_collector
  import serial_byte_collector_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int BUF_D  = DEF_BUF_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ser_in,
  input  logic              i_ser_in_valid,
  input  logic              i_en,
  output logic              o_rd_en,
  output logic [DATA_W-1:0] o_byte_out,
  output logic              o_byte_out_valid,
  input  logic              i_byte_out_ready,
  output logic              o_frag_err,
  output logic              o_ovf_err,
  input  logic              i_clr_err
);
  // only the DATA_W-1 most recent bits need storing; the newest comes straight from i_ser_in
  logic [DATA_W-2:0] r_sr;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_frag, r_rd_en;
  logic [DATA_W-1:0] w_word;
  logic              w_last;
  always_comb begin
    w_word = {i_ser_in, r_sr};
    w_last = i_ser_in_valid & (r_bit_cnt == CNT_W'(DATA_W - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_frag    <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      if (i_ser_in_valid) r_sr <= w_word[DATA_W-1:1];
      r_bit_cnt <= (!i_ser_in_valid || w_last) ? '0 : r_bit_cnt + 1'b1;
      r_frag    <= ~i_ser_in_valid & (r_bit_cnt != '0);
      r_rd_en   <= i_en & ~o_byte_out_valid & (r_bit_cnt == '0) & ~i_ser_in_valid;
    end
  end
  assign o_frag_err = r_frag;
  assign o_rd_en    = r_rd_en;
  collector_out_buf #(.DATA_W(DATA_W), .BUF_D(BUF_D)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_last),
    .i_data  (w_word),
    .i_ready (i_byte_out_ready),
    .i_clr   (i_clr_err),
    .o_data  (o_byte_out),
    .o_valid (o_byte_out_valid),
    .o_ovf   (o_ovf_err)
  );
endmodule

// File: tb/tb_serial_byte_collector.sv
// tb_serial_byte_collector: directed plan plus random traffic against a queue-based reference model
module tb_serial_byte_collector;
  localparam int DW = 8;
  localparam int BD = 2;
  logic clk = 0, rst_n = 0;
  logic ser = 0, vld = 0, en = 0, rdy = 0, clr = 0;
  logic rd_en, bvld, frag, ovf;
  logic [DW-1:0] bout;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mq[$];
  bit mbits[$];
  logic m_rd = 0, m_frag = 0, m_ovf = 0;

  serial_byte_collector dut (
    .clk(clk), .rst_n(rst_n), .i_ser_in(ser), .i_ser_in_valid(vld), .i_en(en),
    .o_rd_en(rd_en), .o_byte_out(bout), .o_byte_out_valid(bvld),
    .i_byte_out_ready(rdy), .o_frag_err(frag), .o_ovf_err(ovf), .i_clr_err(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbits.delete();
    m_rd = 0;
    m_frag = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    bit pop, set;
    logic [DW-1:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop = mq.size() > 0 && rdy;
    m_rd = en && mq.size() == 0 && mbits.size() == 0 && !vld;
    m_frag = !vld && mbits.size() != 0;
    set = 0;
    if (pop) void'(mq.pop_front());
    if (vld) begin
      mbits.push_back(ser);
      if (mbits.size() == DW) begin
        w = '0;
        foreach (mbits[i]) w[i] = mbits[i];
        if (mq.size() < BD) mq.push_back(w);
        else set = 1;
        mbits.delete();
      end
    end else mbits.delete();
    m_ovf = set || (m_ovf && !clr);
  endtask

  task automatic compare();
    chk("rd_en", rd_en, m_rd);
    chk("byte_out_valid", bvld, mq.size() != 0);
    if (mq.size() != 0) chk("byte_out", bout, mq[0]);
    chk("frag_err", frag, m_frag);
    chk("ovf_err", ovf, m_ovf);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (rst_n) compare();
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      ser = w[i];
      vld = 1;
      cyc();
    end
    vld = 0;
  endtask

  task automatic idle(input int n);
    vld = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #2;
    chk("reset rd_en", rd_en, 0);
    chk("reset byte_out", bout, 0);
    chk("reset valid", bvld, 0);
    chk("reset frag", frag, 0);
    chk("reset ovf", ovf, 0);
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1;
    en = 1;
    rdy = 1;
    idle(3);
    chk("idle rd_en", rd_en, 1);
    send_word(8'hA5);
    chk("a5 word", bout, 8'hA5);
    chk("a5 rd_en low", rd_en, 0);
    idle(3);
    for (int k = 0; k < 2 * DW; k++) begin
      logic [2*DW-1:0] pair;
      pair = 16'hC33C;
      ser = pair[k];
      vld = 1;
      cyc();
      if (k == DW - 1) chk("b2b first", bout, 8'h3C);
    end
    chk("b2b second", bout, 8'hC3);
    idle(3);
    rdy = 0;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    chk("ovf set", ovf, 1);
    chk("ovf head", bout, 8'h11);
    rdy = 1;
    cyc();
    chk("drain second", bout, 8'h22);
    cyc();
    chk("drained", bvld, 0);
    clr = 1;
    cyc();
    clr = 0;
    chk("ovf cleared", ovf, 0);
    rdy = 0;
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 0; i < DW; i++) begin
      logic [DW-1:0] w3;
      w3 = 8'h33;
      ser = w3[i];
      vld = 1;
      rdy = (i == DW - 1);
      cyc();
    end
    vld = 0;
    rdy = 0;
    cyc();
    chk("sim pop head", bout, 8'h22);
    chk("sim pop ovf", ovf, 0);
    rdy = 1;
    idle(4);
    for (int i = 0; i < 5; i++) begin
      ser = i[0];
      vld = 1;
      cyc();
    end
    vld = 0;
    cyc();
    chk("frag pulse", frag, 1);
    cyc();
    chk("frag gone", frag, 0);
    send_word(8'h5A);
    chk("post frag word", bout, 8'h5A);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      ser = 1;
      vld = 1;
      cyc();
    end
    rst_n = 0;
    vld = 0;
    #1;
    model_reset();
    chk("mid rst rd_en", rd_en, 0);
    chk("mid rst byte_out", bout, 0);
    chk("mid rst valid", bvld, 0);
    chk("mid rst frag", frag, 0);
    chk("mid rst ovf", ovf, 0);
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1;
    cyc();
    send_word(8'h96);
    chk("post rst word", bout, 8'h96);
    chk("post rst frag", frag, 0);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      ser = $urandom_range(0, 1);
      vld = $urandom_range(0, 15) != 0;
      rdy = $urandom_range(0, 9) < 7;
      en = $urandom_range(0, 9) != 0;
      clr = $urandom_range(0, 31) == 0;
      cyc();
    end
    clr = 0;
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
